// File: rtl/ifm_s2mm_axis_pkg.sv
// ifm_s2mm_axis_pkg
//   Shared definitions for the IFM S2MM AXI-Stream bridge:
//   FSM state encodings, FIFO word field positions and stream widths.
package ifm_s2mm_axis_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_LAST = 2'd2,
      S_STS  = 2'd3
   } state_t;

   // good FIFO word: [72] last, [71:64] keep, [63:0] data
   localparam int GF_W       = 73;
   localparam int GF_LAST    = 72;
   localparam int GF_KEEP_HI = 71;
   localparam int GF_KEEP_LO = 64;

   // ctrl FIFO word: [36] last, [35:32] keep, [31:0] data
   localparam int CF_W       = 37;
   localparam int CF_LAST    = 36;
   localparam int CF_KEEP_HI = 35;
   localparam int CF_KEEP_LO = 32;

   localparam int S2MM_DATA_W = 64;
   localparam int S2MM_KEEP_W = 8;
   localparam int STS_DATA_W  = 32;
   localparam int STS_KEEP_W  = 4;

endpackage

// File: rtl/ifm_s2mm_axis_out_reg.sv
// axis_out_reg
//   Single-stage valid/ready output register. A load captures din and
//   raises valid; without a load, an accepted beat (ready=1) drops valid.
//   can_load tells the producer the register is free this cycle.
// Ports:
//   s2mm_clk, s2mm_resetn : clock, async active-low reset
//   load, din             : capture strobe and word
//   ready                 : downstream ready
//   valid, dout           : registered stream word
//   can_load              : ~valid | ready
module axis_out_reg #(
   parameter int W = 8
) (
   input  logic         s2mm_clk,
   input  logic         s2mm_resetn,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic         can_load
);

   assign can_load = ~valid | ready;

   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifm_s2mm_axis.sv
// ifm_s2mm_axis
//   Drains one frame from the good (data) FIFO onto the S2MM data stream,
//   then its status packet from the ctrl FIFO onto the S2MM status stream,
//   and counts completed frames. Frames are strictly serialised: the next
//   frame's data is not popped until the current status tlast is accepted.
// Ports:
//   s2mm_clk, s2mm_resetn          : clock, async active-low reset
//   good_fifo_*                    : FWFT frame data FIFO (rdata/empty/rden)
//   ctrl_fifo_*                    : FWFT status FIFO (rdata/empty/rden)
//   s2mm_t*                        : DMA data stream (64-bit)
//   s2mm_sts_t*                    : DMA status/app stream (32-bit)
//   rx_frame_cnt                   : frames fully delivered (wrapping)
//   ifm_s2mm_fsm_dbg               : {tready, good_fifo_empty, state}
module ifm_s2mm_axis
   import ifm_s2mm_axis_pkg::*;
#(
   parameter int C_CNT_W = 32
) (
   input  logic                   s2mm_clk,
   input  logic                   s2mm_resetn,
   input  logic [GF_W-1:0]        good_fifo_rdata,
   input  logic                   good_fifo_empty,
   output logic                   good_fifo_rden,
   input  logic [CF_W-1:0]        ctrl_fifo_rdata,
   input  logic                   ctrl_fifo_empty,
   output logic                   ctrl_fifo_rden,
   output logic [S2MM_DATA_W-1:0] s2mm_tdata,
   output logic [S2MM_KEEP_W-1:0] s2mm_tkeep,
   output logic                   s2mm_tlast,
   output logic                   s2mm_tvalid,
   input  logic                   s2mm_tready,
   output logic [STS_DATA_W-1:0]  s2mm_sts_tdata,
   output logic [STS_KEEP_W-1:0]  s2mm_sts_tkeep,
   output logic                   s2mm_sts_tlast,
   output logic                   s2mm_sts_tvalid,
   input  logic                   s2mm_sts_tready,
   output logic [C_CNT_W-1:0]     rx_frame_cnt,
   output logic [3:0]             ifm_s2mm_fsm_dbg
);

   state_t          state, state_nxt;
   logic [GF_W-1:0] d_q;
   logic [CF_W-1:0] c_q;
   logic            d_can_load, c_can_load;
   logic            d_last_hs, s_last_hs;

   // ---------------- output registers ----------------
   axis_out_reg #(.W(GF_W)) u_data_reg (
      .s2mm_clk    (s2mm_clk),
      .s2mm_resetn (s2mm_resetn),
      .load        (good_fifo_rden),
      .din         (good_fifo_rdata),
      .ready       (s2mm_tready),
      .valid       (s2mm_tvalid),
      .dout        (d_q),
      .can_load    (d_can_load)
   );

   axis_out_reg #(.W(CF_W)) u_sts_reg (
      .s2mm_clk    (s2mm_clk),
      .s2mm_resetn (s2mm_resetn),
      .load        (ctrl_fifo_rden),
      .din         (ctrl_fifo_rdata),
      .ready       (s2mm_sts_tready),
      .valid       (s2mm_sts_tvalid),
      .dout        (c_q),
      .can_load    (c_can_load)
   );

   assign s2mm_tdata     = d_q[S2MM_DATA_W-1:0];
   assign s2mm_tkeep     = d_q[GF_KEEP_HI:GF_KEEP_LO];
   assign s2mm_tlast     = d_q[GF_LAST];
   assign s2mm_sts_tdata = c_q[STS_DATA_W-1:0];
   assign s2mm_sts_tkeep = c_q[CF_KEEP_HI:CF_KEEP_LO];
   assign s2mm_sts_tlast = c_q[CF_LAST];

   assign d_last_hs = s2mm_tvalid & s2mm_tready & s2mm_tlast;
   assign s_last_hs = s2mm_sts_tvalid & s2mm_sts_tready & s2mm_sts_tlast;

   // ---------------- FSM ----------------
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (!good_fifo_empty)                       state_nxt = S_DATA;
         S_DATA: if (good_fifo_rden && good_fifo_rdata[GF_LAST]) state_nxt = S_LAST;
         S_LAST: if (d_last_hs)                              state_nxt = S_STS;
         S_STS:  if (s_last_hs)                              state_nxt = S_IDLE;
         default:                                            state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      good_fifo_rden = 1'b0;
      ctrl_fifo_rden = 1'b0;
      case (state)
         S_DATA: good_fifo_rden = ~good_fifo_empty & d_can_load;
         // Once the status tlast word sits in the register, stop popping:
         // the FSM is still in S_STS while that word waits for acceptance,
         // and the next word in the ctrl FIFO belongs to a later frame.
         S_STS:  ctrl_fifo_rden = ~ctrl_fifo_empty & c_can_load &
                                  ~(s2mm_sts_tvalid & s2mm_sts_tlast);
         default: ;
      endcase
   end

   // ---------------- frame counter ----------------
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn)                  rx_frame_cnt <= '0;
      else if (state == S_STS && s_last_hs) rx_frame_cnt <= rx_frame_cnt + C_CNT_W'(1);
   end

   assign ifm_s2mm_fsm_dbg = {s2mm_tready, good_fifo_empty, state};

endmodule

// File: tb/tb_ifm_s2mm_axis.sv
// tb_ifm_s2mm_axis
//   Directed bench for ifm_s2mm_axis: FWFT FIFO models feed the DUT, a
//   posedge monitor records accepted beats and event cycles, and a single
//   initial block walks through the scenarios checking hand-built words.
module tb_ifm_s2mm_axis;

   logic        s2mm_clk = 1'b0;
   logic        s2mm_resetn = 1'b0;
   logic [72:0] good_fifo_rdata;
   logic        good_fifo_empty;
   logic        good_fifo_rden;
   logic [36:0] ctrl_fifo_rdata;
   logic        ctrl_fifo_empty;
   logic        ctrl_fifo_rden;
   logic [63:0] s2mm_tdata;
   logic [7:0]  s2mm_tkeep;
   logic        s2mm_tlast, s2mm_tvalid;
   logic        s2mm_tready = 1'b1;
   logic [31:0] s2mm_sts_tdata;
   logic [3:0]  s2mm_sts_tkeep;
   logic        s2mm_sts_tlast, s2mm_sts_tvalid;
   logic        s2mm_sts_tready = 1'b1;
   logic [31:0] rx_frame_cnt;
   logic [3:0]  ifm_s2mm_fsm_dbg;

   always #5 s2mm_clk = ~s2mm_clk;

   ifm_s2mm_axis #(.C_CNT_W(32)) dut (
      .s2mm_clk         (s2mm_clk),
      .s2mm_resetn      (s2mm_resetn),
      .good_fifo_rdata  (good_fifo_rdata),
      .good_fifo_empty  (good_fifo_empty),
      .good_fifo_rden   (good_fifo_rden),
      .ctrl_fifo_rdata  (ctrl_fifo_rdata),
      .ctrl_fifo_empty  (ctrl_fifo_empty),
      .ctrl_fifo_rden   (ctrl_fifo_rden),
      .s2mm_tdata       (s2mm_tdata),
      .s2mm_tkeep       (s2mm_tkeep),
      .s2mm_tlast       (s2mm_tlast),
      .s2mm_tvalid      (s2mm_tvalid),
      .s2mm_tready      (s2mm_tready),
      .s2mm_sts_tdata   (s2mm_sts_tdata),
      .s2mm_sts_tkeep   (s2mm_sts_tkeep),
      .s2mm_sts_tlast   (s2mm_sts_tlast),
      .s2mm_sts_tvalid  (s2mm_sts_tvalid),
      .s2mm_sts_tready  (s2mm_sts_tready),
      .rx_frame_cnt     (rx_frame_cnt),
      .ifm_s2mm_fsm_dbg (ifm_s2mm_fsm_dbg)
   );

   // ---------------- FWFT FIFO models ----------------
   logic [72:0] gmem [0:63];
   logic [36:0] cmem [0:63];
   logic [5:0]  gwr = '0, grd = '0, cwr = '0, crd = '0;
   logic        c_block = 1'b0;
   logic        flush = 1'b0;

   assign good_fifo_empty = (gwr == grd);
   assign good_fifo_rdata = gmem[grd];
   assign ctrl_fifo_empty = (cwr == crd) | c_block;
   assign ctrl_fifo_rdata = cmem[crd];

   // ---------------- monitor ----------------
   logic [72:0] cap_d [0:255];
   logic [36:0] cap_s [0:255];
   int          dcyc [0:255];
   int          pcyc [0:255];
   int          scyc [0:255];
   int          n_d = 0, n_s = 0, n_p = 0, n_f = 0, cyc = 0;

   always @(posedge s2mm_clk) begin
      cyc <= cyc + 1;
      if (s2mm_tvalid && s2mm_tready) begin
         cap_d[n_d] <= {s2mm_tlast, s2mm_tkeep, s2mm_tdata};
         dcyc[n_d]  <= cyc;
         n_d        <= n_d + 1;
      end
      if (s2mm_sts_tvalid && s2mm_sts_tready) begin
         cap_s[n_s] <= {s2mm_sts_tlast, s2mm_sts_tkeep, s2mm_sts_tdata};
         n_s        <= n_s + 1;
         if (s2mm_sts_tlast) begin
            scyc[n_f] <= cyc;
            n_f       <= n_f + 1;
         end
      end
      if (good_fifo_rden) begin
         pcyc[n_p] <= cyc;
         n_p       <= n_p + 1;
      end
      if (flush) begin
         grd <= gwr;
         crd <= cwr;
      end else begin
         if (good_fifo_rden) grd <= grd + 6'd1;
         if (ctrl_fifo_rden) crd <= crd + 6'd1;
      end
   end

   // ---------------- helpers ----------------
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [72:0] mkg(input logic l, input logic [7:0] k, input logic [63:0] d);
      return {l, k, d};
   endfunction

   function automatic logic [36:0] mkc(input logic l, input logic [3:0] k, input logic [31:0] d);
      return {l, k, d};
   endfunction

   task automatic push_g(input logic [72:0] w);
      gmem[gwr] = w;
      gwr = gwr + 6'd1;
   endtask

   task automatic push_c(input logic [36:0] w);
      cmem[cwr] = w;
      cwr = cwr + 6'd1;
   endtask

   task automatic wait_for(input int td, input int ts, input string tag);
      int k = 0;
      while ((n_d < td || n_s < ts) && k < 300) begin
         @(negedge s2mm_clk);
         k++;
      end
      chk(tag, {127'd0, (n_d >= td && n_s >= ts)}, 128'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [72:0] ed [0:7];
   logic [36:0] es [0:7];
   int bd, bs, bp, bf, k;

   initial begin
      // reset state
      repeat (3) @(negedge s2mm_clk);
      chk("rst_dbg",      ifm_s2mm_fsm_dbg, 4'b1100);
      chk("rst_tvalid",   s2mm_tvalid, 1'b0);
      chk("rst_stsvalid", s2mm_sts_tvalid, 1'b0);
      chk("rst_cnt",      rx_frame_cnt, 32'd0);
      chk("rst_rden",     {good_fifo_rden, ctrl_fifo_rden}, 2'b00);
      chk("rst_data",     {s2mm_tlast, s2mm_tkeep, s2mm_tdata}, 73'd0);
      s2mm_resetn = 1'b1;
      @(negedge s2mm_clk);

      // T1: 3-word frame, 6-word status, back-pressure free
      bd = n_d; bs = n_s; bp = n_p;
      ed[0] = mkg(1'b0, 8'hFF, 64'h1111_2222_3333_0A00);
      ed[1] = mkg(1'b0, 8'h00, 64'h1111_2222_3333_0A01);
      ed[2] = mkg(1'b1, 8'h0F, 64'h1111_2222_3333_0A02);
      for (int i = 0; i < 3; i++) push_g(ed[i]);
      for (int i = 0; i < 6; i++) begin
         es[i] = mkc(i == 5, 4'hF, 32'h5000_0000 + i);
         push_c(es[i]);
      end
      wait_for(bd + 3, bs + 6, "t1_done");
      for (int i = 0; i < 3; i++) chk($sformatf("t1_d%0d", i), cap_d[bd+i], ed[i]);
      chk("t1_lat",   dcyc[bd], pcyc[bp] + 1);
      chk("t1_b2",    dcyc[bd+1], dcyc[bd] + 1);
      chk("t1_b3",    dcyc[bd+2], dcyc[bd] + 2);
      for (int i = 0; i < 6; i++) chk($sformatf("t1_s%0d", i), cap_s[bs+i], es[i]);
      chk("t1_cnt",   rx_frame_cnt, 32'd1);
      chk("t1_state", ifm_s2mm_fsm_dbg[1:0], 2'd0);

      // T2: 5-cycle tready stall mid-frame
      @(negedge s2mm_clk);
      bd = n_d; bs = n_s;
      for (int i = 0; i < 4; i++) begin
         ed[i] = mkg(i == 3, 8'hFF, 64'hB0 + i);
         push_g(ed[i]);
      end
      push_c(mkc(1'b1, 4'h3, 32'hC0));
      k = 0;
      while (n_d < bd + 2 && k < 100) begin @(negedge s2mm_clk); k++; end
      s2mm_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t2_rden%0d", i), good_fifo_rden, 1'b0);
         chk($sformatf("t2_hold%0d", i), {s2mm_tvalid, s2mm_tdata}, {1'b1, 64'hB2});
         @(negedge s2mm_clk);
      end
      s2mm_tready = 1'b1;
      wait_for(bd + 4, bs + 1, "t2_done");
      repeat (3) @(negedge s2mm_clk);
      chk("t2_ndata", n_d, bd + 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_d%0d", i), cap_d[bd+i], ed[i]);
      chk("t2_sts",   cap_s[bs], mkc(1'b1, 4'h3, 32'hC0));
      chk("t2_cnt",   rx_frame_cnt, 32'd2);

      // T3: ctrl FIFO empty for 10 cycles after data tlast
      bd = n_d; bs = n_s;
      c_block = 1'b1;
      push_g(mkg(1'b0, 8'hFF, 64'hF0));
      push_g(mkg(1'b1, 8'h01, 64'hF1));
      for (int i = 0; i < 6; i++) begin
         es[i] = mkc(i == 5, 4'hA, 32'hD0 + i);
         push_c(es[i]);
      end
      k = 0;
      while (ifm_s2mm_fsm_dbg[1:0] != 2'd3 && k < 100) begin @(negedge s2mm_clk); k++; end
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t3_wait%0d", i), {ifm_s2mm_fsm_dbg[1:0], s2mm_sts_tvalid}, 3'b110);
         @(negedge s2mm_clk);
      end
      c_block = 1'b0;
      wait_for(bd + 2, bs + 6, "t3_done");
      chk("t3_dlast", cap_d[bd+1], mkg(1'b1, 8'h01, 64'hF1));
      for (int i = 0; i < 6; i++) chk($sformatf("t3_s%0d", i), cap_s[bs+i], es[i]);
      chk("t3_cnt",   rx_frame_cnt, 32'd3);

      // T4: two frames queued back to back
      @(negedge s2mm_clk);
      bd = n_d; bs = n_s; bp = n_p; bf = n_f;
      push_g(mkg(1'b0, 8'hFF, 64'hA0));
      push_g(mkg(1'b1, 8'hFF, 64'hA1));
      push_g(mkg(1'b0, 8'hFF, 64'hE0));
      push_g(mkg(1'b1, 8'h03, 64'hE1));
      push_c(mkc(1'b1, 4'h1, 32'hAA));
      push_c(mkc(1'b1, 4'h2, 32'hEE));
      wait_for(bd + 4, bs + 2, "t4_done");
      chk("t4_gap",  pcyc[bp+2], scyc[bf] + 2);
      chk("t4_d2",   cap_d[bd+2], mkg(1'b0, 8'hFF, 64'hE0));
      chk("t4_s1",   cap_s[bs+1], mkc(1'b1, 4'h2, 32'hEE));
      chk("t4_cnt",  rx_frame_cnt, 32'd5);

      // T5: async reset while beat 2 is held
      @(negedge s2mm_clk);
      bd = n_d;
      for (int i = 0; i < 4; i++) push_g(mkg(i == 3, 8'hFF, 64'h70 + i));
      push_c(mkc(1'b1, 4'hF, 32'h77));
      k = 0;
      while (n_d < bd + 1 && k < 100) begin @(negedge s2mm_clk); k++; end
      #2 s2mm_resetn = 1'b0;
      #1;
      chk("t5_state",  ifm_s2mm_fsm_dbg[1:0], 2'd0);
      chk("t5_valids", {s2mm_tvalid, s2mm_sts_tvalid}, 2'b00);
      chk("t5_rden",   {good_fifo_rden, ctrl_fifo_rden}, 2'b00);
      chk("t5_cnt",    rx_frame_cnt, 32'd0);
      flush = 1'b1;
      @(negedge s2mm_clk);
      flush = 1'b0;
      s2mm_resetn = 1'b1;
      @(negedge s2mm_clk);
      bd = n_d; bs = n_s;
      for (int i = 0; i < 3; i++) begin
         ed[i] = mkg(i == 2, 8'h3C, 64'h9000 + i);
         push_g(ed[i]);
      end
      push_c(mkc(1'b1, 4'h5, 32'h99));
      wait_for(bd + 3, bs + 1, "t5_done");
      for (int i = 0; i < 3; i++) chk($sformatf("t5_d%0d", i), cap_d[bd+i], ed[i]);
      chk("t5_sts",   cap_s[bs], mkc(1'b1, 4'h5, 32'h99));
      chk("t5_cnt1",  rx_frame_cnt, 32'd1);

      // T6: counter wrap
      @(negedge s2mm_clk);
      force dut.rx_frame_cnt = 32'hFFFF_FFFF;
      @(negedge s2mm_clk);
      release dut.rx_frame_cnt;
      #1;
      chk("t6_pre",  rx_frame_cnt, 32'hFFFF_FFFF);
      bd = n_d; bs = n_s;
      push_g(mkg(1'b1, 8'h80, 64'hCAFE));
      push_c(mkc(1'b1, 4'h1, 32'h1));
      wait_for(bd + 1, bs + 1, "t6_done");
      chk("t6_d0",   cap_d[bd], mkg(1'b1, 8'h80, 64'hCAFE));
      chk("t6_wrap", rx_frame_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
